// File: rtl/mem_lsu.sv
// MEM pipeline stage: ALU/CSR pass-through, plus a 3-state bus FSM for loads and stores that also aligns load data.
// Optional bus watchdog: define MEM_LSU_TIMEOUT_EN.
module mem_lsu #(
  parameter int DATA_W      = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int CSR_ADDR_W  = 12,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clk_in,
  input  logic                  reset_n_in,
  input  logic                  mem_req_in,
  input  logic                  mem_we_in,
  input  logic [1:0]            mem_size_in,
  input  logic                  mem_unsigned_in,
  input  logic [DATA_W-1:0]     mem_addr_in,
  input  logic [DATA_W-1:0]     mem_wdata_in,
  input  logic [DATA_W-1:0]     reg_wdata_in,
  input  logic [REG_ADDR_W-1:0] reg_waddr_in,
  input  logic                  reg_we_in,
  input  logic [DATA_W-1:0]     csr_wdata_in,
  input  logic [CSR_ADDR_W-1:0] csr_waddr_in,
  input  logic                  csr_we_in,
  input  logic                  interrupt_flush_in,
  output logic [DATA_W-1:0]     reg_wdata_out,
  output logic [REG_ADDR_W-1:0] reg_waddr_out,
  output logic                  reg_we_out,
  output logic [DATA_W-1:0]     csr_wdata_out,
  output logic [CSR_ADDR_W-1:0] csr_waddr_out,
  output logic                  csr_we_out,
  output logic                  stall_req_out,
  output logic                  misaligned_out,
  output logic                  access_fault_out,
  output logic                  bus_req_out,
  output logic                  bus_we_out,
  output logic [DATA_W-1:0]     bus_addr_out,
  output logic [DATA_W-1:0]     bus_wdata_out,
  output logic [3:0]            bus_be_out,
  input  logic                  bus_ack_in,
  input  logic [DATA_W-1:0]     bus_rdata_in
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] addr_reg, wdata_reg, load_reg;
  logic [3:0]        be_reg;
  logic [1:0]        size_reg;
  logic              we_reg, unsigned_reg, drop_reg;

  logic              misaligned, accept, timed_out;
  logic [3:0]        st_be;
  logic [DATA_W-1:0] st_data, load_aligned;
  logic [7:0]        rbyte [4];
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign rbyte[gi] = bus_rdata_in[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    case (mem_size_in)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = mem_addr_in[0];
      2'b10:   misaligned = |mem_addr_in[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  assign accept = (state_reg == IDLE) && mem_req_in && !misaligned && !interrupt_flush_in;

  // Store data is replicated across lanes so the slave only has to honour byte enables.
  always_comb begin
    st_be   = 4'b1111;
    st_data = mem_wdata_in;
    if (mem_we_in) begin
      case (mem_size_in)
        2'b00: begin
          st_be   = 4'b0001 << mem_addr_in[1:0];
          st_data = {4{mem_wdata_in[7:0]}};
        end
        2'b01: begin
          st_be   = mem_addr_in[1] ? 4'b1100 : 4'b0011;
          st_data = {2{mem_wdata_in[15:0]}};
        end
        default: ;
      endcase
    end
  end

  assign ld_byte = rbyte[addr_reg[1:0]];
  assign ld_half = addr_reg[1] ? bus_rdata_in[31:16] : bus_rdata_in[15:0];

  always_comb begin
    case (size_reg)
      2'b00:   load_aligned = unsigned_reg ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   load_aligned = unsigned_reg ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: load_aligned = bus_rdata_in;
    endcase
  end

`ifdef MEM_LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in)            cnt_reg <= '0;
    else if (state_reg == BUS)  cnt_reg <= cnt_reg + 1'b1;
    else                        cnt_reg <= '0;
  end

  assign timed_out = (state_reg == BUS) && (cnt_reg == CNT_W'(TIMEOUT_CYC));
  assign access_fault_out = timed_out && reset_n_in;
`else
  assign timed_out        = 1'b0;
  assign access_fault_out = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      load_reg     <= '0;
      be_reg       <= '0;
      size_reg     <= '0;
      we_reg       <= 1'b0;
      unsigned_reg <= 1'b0;
      drop_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        addr_reg     <= mem_addr_in;
        wdata_reg    <= st_data;
        be_reg       <= st_be;
        size_reg     <= mem_size_in;
        we_reg       <= mem_we_in;
        unsigned_reg <= mem_unsigned_in;
        drop_reg     <= 1'b0;
      end
      if (state_reg == BUS) begin
        if (interrupt_flush_in) drop_reg <= 1'b1;
        if (bus_ack_in && !timed_out) load_reg <= load_aligned;
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    reg_wdata_out  = reg_wdata_in;
    reg_waddr_out  = reg_waddr_in;
    reg_we_out     = 1'b0;
    csr_wdata_out  = csr_wdata_in;
    csr_waddr_out  = csr_waddr_in;
    csr_we_out     = 1'b0;
    stall_req_out  = 1'b0;
    misaligned_out = 1'b0;
    bus_req_out    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (interrupt_flush_in) begin
          reg_wdata_out = '0;
          reg_waddr_out = '0;
          csr_wdata_out = '0;
          csr_waddr_out = '0;
        end else if (mem_req_in) begin
          if (misaligned) begin
            misaligned_out = 1'b1;
          end else begin
            stall_req_out = 1'b1;
            state_next    = BUS;
          end
        end else begin
          reg_we_out = reg_we_in;
          csr_we_out = csr_we_in;
        end
      end
      BUS: begin
        if (timed_out) begin
          state_next = IDLE;
        end else begin
          bus_req_out   = 1'b1;
          stall_req_out = 1'b1;
          // A flushed access still completes on the bus but never writes back.
          if (bus_ack_in) state_next = (drop_reg || interrupt_flush_in) ? IDLE : DONE;
        end
      end
      DONE: begin
        if (!we_reg) reg_wdata_out = load_reg;
        if (!interrupt_flush_in) begin
          reg_we_out = reg_we_in;
          csr_we_out = csr_we_in;
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (!reset_n_in) begin
      reg_we_out     = 1'b0;
      csr_we_out     = 1'b0;
      stall_req_out  = 1'b0;
      misaligned_out = 1'b0;
      bus_req_out    = 1'b0;
    end
  end

  assign bus_we_out    = we_reg;
  assign bus_addr_out  = {addr_reg[DATA_W-1:2], 2'b00};
  assign bus_wdata_out = wdata_reg;
  assign bus_be_out    = be_reg;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu: pass-through, loads, stores, misalignment, flush and watchdog.
module tb_mem_lsu;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_req = 0, mem_we = 0, mem_unsigned = 0;
  logic [1:0]  mem_size = 0;
  logic [31:0] mem_addr = 0, mem_wdata = 0, reg_wdata = 0, csr_wdata = 0, bus_rdata = 0;
  logic [4:0]  reg_waddr = 0;
  logic [11:0] csr_waddr = 0;
  logic        reg_we = 0, csr_we = 0, flush = 0, bus_ack = 0;
  logic [31:0] reg_wdata_o, csr_wdata_o, bus_addr, bus_wdata;
  logic [4:0]  reg_waddr_o;
  logic [11:0] csr_waddr_o;
  logic        reg_we_o, csr_we_o, stall, misaligned, fault, bus_req, bus_we;
  logic [3:0]  bus_be;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_lsu #(.DATA_W(32), .REG_ADDR_W(5), .CSR_ADDR_W(12), .TIMEOUT_CYC(4)) dut (
    .clk_in(clk), .reset_n_in(reset_n),
    .mem_req_in(mem_req), .mem_we_in(mem_we), .mem_size_in(mem_size), .mem_unsigned_in(mem_unsigned),
    .mem_addr_in(mem_addr), .mem_wdata_in(mem_wdata),
    .reg_wdata_in(reg_wdata), .reg_waddr_in(reg_waddr), .reg_we_in(reg_we),
    .csr_wdata_in(csr_wdata), .csr_waddr_in(csr_waddr), .csr_we_in(csr_we),
    .interrupt_flush_in(flush),
    .reg_wdata_out(reg_wdata_o), .reg_waddr_out(reg_waddr_o), .reg_we_out(reg_we_o),
    .csr_wdata_out(csr_wdata_o), .csr_waddr_out(csr_waddr_o), .csr_we_out(csr_we_o),
    .stall_req_out(stall), .misaligned_out(misaligned), .access_fault_out(fault),
    .bus_req_out(bus_req), .bus_we_out(bus_we), .bus_addr_out(bus_addr),
    .bus_wdata_out(bus_wdata), .bus_be_out(bus_be),
    .bus_ack_in(bus_ack), .bus_rdata_in(bus_rdata)
  );

  task automatic test_reset;
    reg_we = 1; csr_we = 1; mem_req = 1; mem_size = 2'b11;
    #2;
    checks++; if (reg_we_o !== 1'b0) begin errors++; $display("FAIL reset_reg_we: got %b want 0", reg_we_o); end
    checks++; if (csr_we_o !== 1'b0) begin errors++; $display("FAIL reset_csr_we: got %b want 0", csr_we_o); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
    checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL reset_misaligned: got %b want 0", misaligned); end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_bus_req: got %b want 0", bus_req); end
    @(negedge clk); @(negedge clk);
    reg_we = 0; csr_we = 0; mem_req = 0; mem_size = 0;
    reset_n = 1;
    $display("reset released");
  endtask

  task automatic test_passthrough;
    @(negedge clk);
    reg_wdata = 32'h1234; reg_waddr = 5; reg_we = 1; csr_wdata = 32'h55; csr_waddr = 12'h300; csr_we = 1;
    #1;
    checks++; if (reg_wdata_o !== 32'h1234) begin errors++; $display("FAIL pt_wdata: got %h want 00001234", reg_wdata_o); end
    checks++; if (reg_waddr_o !== 5'd5) begin errors++; $display("FAIL pt_waddr: got %0d want 5", reg_waddr_o); end
    checks++; if (reg_we_o !== 1'b1) begin errors++; $display("FAIL pt_we: got %b want 1", reg_we_o); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL pt_stall: got %b want 0", stall); end
    checks++; if (csr_we_o !== 1'b1 || csr_waddr_o !== 12'h300) begin errors++; $display("FAIL pt_csr: got we=%b addr=%h want we=1 addr=300", csr_we_o, csr_waddr_o); end
    $display("alu pass-through wdata=%h waddr=%0d", reg_wdata_o, reg_waddr_o);
    csr_we = 0;
  endtask

  task automatic test_lb;
    int stall_cnt = 0;
    @(negedge clk);
    mem_req = 1; mem_we = 0; mem_size = 2'b00; mem_unsigned = 0; mem_addr = 32'h103;
    reg_we = 1; reg_waddr = 7; reg_wdata = 32'h103;
    #1;
    stall_cnt += int'(stall);
    checks++; if (stall !== 1'b1 || reg_we_o !== 1'b0 || bus_req !== 1'b0) begin errors++; $display("FAIL lb_idle: got stall=%b we=%b req=%b want 1 0 0", stall, reg_we_o, bus_req); end
    @(negedge clk);
    bus_ack = 1; bus_rdata = 32'h80FF_FF00;
    #1;
    stall_cnt += int'(stall);
    checks++; if (bus_req !== 1'b1 || bus_we !== 1'b0) begin errors++; $display("FAIL lb_bus_req: got req=%b we=%b want 1 0", bus_req, bus_we); end
    checks++; if (bus_be !== 4'b1111) begin errors++; $display("FAIL lb_be: got %b want 1111", bus_be); end
    checks++; if (bus_addr !== 32'h100) begin errors++; $display("FAIL lb_addr: got %h want 00000100", bus_addr); end
    @(negedge clk);
    bus_ack = 0;
    #1;
    stall_cnt += int'(stall);
    checks++; if (reg_wdata_o !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data: got %h want ffffff80", reg_wdata_o); end
    checks++; if (reg_we_o !== 1'b1 || reg_waddr_o !== 5'd7) begin errors++; $display("FAIL lb_wb: got we=%b addr=%0d want 1 7", reg_we_o, reg_waddr_o); end
    checks++; if (stall_cnt != 2) begin errors++; $display("FAIL lb_stall_cycles: got %0d want 2", stall_cnt); end
    $display("lb addr=103 result=%h stall_cycles=%0d", reg_wdata_o, stall_cnt);
    @(negedge clk);
    mem_req = 0;
    #1;
    checks++; if (stall !== 1'b0 || reg_wdata_o !== 32'h103) begin errors++; $display("FAIL lb_back_idle: got stall=%b wdata=%h want 0 00000103", stall, reg_wdata_o); end
  endtask

  task automatic test_sh;
    int stall_cnt = 0;
    int bad = 0;
    @(negedge clk);
    mem_req = 1; mem_we = 1; mem_size = 2'b01; mem_addr = 32'h102; mem_wdata = 32'hABCD;
    reg_we = 0; reg_wdata = 32'h77;
    #1;
    stall_cnt += int'(stall);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_wdata = 32'h1111_0000 + i;
      bus_ack = (i == 3);
      #1;
      stall_cnt += int'(stall);
      if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_be !== 4'b1100 || bus_wdata !== 32'hABCD_ABCD
          || bus_addr !== 32'h100 || fault !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL sh_bus_stable: %0d bad cycles, last req=%b be=%b wdata=%h addr=%h want 1 1100 abcdabcd 00000100", bad, bus_req, bus_be, bus_wdata, bus_addr); end
    @(negedge clk);
    bus_ack = 0;
    #1;
    stall_cnt += int'(stall);
    checks++; if (stall_cnt != 5) begin errors++; $display("FAIL sh_stall_cycles: got %0d want 5", stall_cnt); end
    checks++; if (reg_wdata_o !== 32'h77 || reg_we_o !== 1'b0) begin errors++; $display("FAIL sh_done: got wdata=%h we=%b want 00000077 0", reg_wdata_o, reg_we_o); end
    $display("sh addr=102 be=1100 wdata=abcdabcd stall_cycles=%0d", stall_cnt);
    @(negedge clk);
    mem_req = 0;
  endtask

  task automatic test_sb;
    @(negedge clk);
    mem_req = 1; mem_we = 1; mem_size = 2'b00; mem_addr = 32'h101; mem_wdata = 32'h1234_565A;
    @(negedge clk);
    bus_ack = 1;
    #1;
    checks++; if (bus_be !== 4'b0010 || bus_wdata !== 32'h5A5A_5A5A) begin errors++; $display("FAIL sb_lane: got be=%b data=%h want 0010 5a5a5a5a", bus_be, bus_wdata); end
    $display("sb addr=101 be=%b wdata=%h", bus_be, bus_wdata);
    @(negedge clk);
    bus_ack = 0;
    @(negedge clk);
    mem_req = 0;
  endtask

  task automatic test_lhu_flush_done;
    @(negedge clk);
    mem_req = 1; mem_we = 0; mem_size = 2'b01; mem_unsigned = 1; mem_addr = 32'h102; reg_we = 1;
    @(negedge clk);
    bus_ack = 1; bus_rdata = 32'h8001_1234;
    @(negedge clk);
    bus_ack = 0; flush = 1;
    #1;
    checks++; if (reg_wdata_o !== 32'h0000_8001) begin errors++; $display("FAIL lhu_data: got %h want 00008001", reg_wdata_o); end
    checks++; if (reg_we_o !== 1'b0) begin errors++; $display("FAIL lhu_flush_done_we: got %b want 0", reg_we_o); end
    $display("lhu addr=102 result=%h flushed_in_done", reg_wdata_o);
    @(negedge clk);
    flush = 0; mem_req = 0; mem_unsigned = 0;
  endtask

  task automatic test_misaligned;
    @(negedge clk);
    mem_req = 1; mem_we = 0; mem_size = 2'b10; mem_addr = 32'h101; reg_we = 1;
    #1;
    checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL mis_lw: got %b want 1", misaligned); end
    checks++; if (reg_we_o !== 1'b0 || stall !== 1'b0 || bus_req !== 1'b0) begin errors++; $display("FAIL mis_lw_side: got we=%b stall=%b req=%b want 0 0 0", reg_we_o, stall, bus_req); end
    @(negedge clk);
    mem_size = 2'b11; mem_addr = 32'h100;
    #1;
    checks++; if (misaligned !== 1'b1 || bus_req !== 1'b0) begin errors++; $display("FAIL mis_size11: got mis=%b req=%b want 1 0", misaligned, bus_req); end
    @(negedge clk);
    mem_size = 2'b01; mem_addr = 32'h102;
    #1;
    checks++; if (misaligned !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL mis_aligned_half: got mis=%b stall=%b want 0 1", misaligned, stall); end
    $display("misaligned lw addr=101 and size=11 rejected");
    @(negedge clk);
    bus_ack = 1;
    @(negedge clk);
    bus_ack = 0; mem_req = 0;
  endtask

  task automatic test_flush;
    @(negedge clk);
    mem_req = 1; mem_we = 0; mem_size = 2'b10; mem_addr = 32'h100; flush = 1; reg_we = 1;
    #1;
    checks++; if (stall !== 1'b0 || reg_we_o !== 1'b0) begin errors++; $display("FAIL flush_idle: got stall=%b we=%b want 0 0", stall, reg_we_o); end
    @(negedge clk);
    flush = 0; mem_size = 2'b01; mem_unsigned = 1; reg_wdata = 32'hCAFE;
    #1;
    checks++; if (bus_req !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL flush_idle_noaccept: got req=%b stall=%b want 0 1", bus_req, stall); end
    @(negedge clk);
    flush = 1;
    #1;
    checks++; if (bus_req !== 1'b1 || stall !== 1'b1) begin errors++; $display("FAIL flush_bus_hold1: got req=%b stall=%b want 1 1", bus_req, stall); end
    @(negedge clk);
    flush = 0;
    #1;
    checks++; if (bus_req !== 1'b1 || stall !== 1'b1) begin errors++; $display("FAIL flush_bus_hold2: got req=%b stall=%b want 1 1", bus_req, stall); end
    @(negedge clk);
    bus_ack = 1; bus_rdata = 32'h8001_1234;
    #1;
    checks++; if (bus_req !== 1'b1 || reg_we_o !== 1'b0) begin errors++; $display("FAIL flush_bus_ack: got req=%b we=%b want 1 0", bus_req, reg_we_o); end
    @(negedge clk);
    bus_ack = 0; mem_req = 0;
    #1;
    checks++; if (reg_wdata_o !== 32'hCAFE || stall !== 1'b0 || bus_req !== 1'b0) begin errors++; $display("FAIL flush_bus_idle: got wdata=%h stall=%b req=%b want 0000cafe 0 0", reg_wdata_o, stall, bus_req); end
    $display("lhu flushed in BUS, request held until ack, no writeback");
    mem_unsigned = 0;
  endtask

`ifdef MEM_LSU_TIMEOUT_EN
  task automatic test_timeout;
    int req_cycles = 0;
    @(negedge clk);
    mem_req = 1; mem_we = 0; mem_size = 2'b10; mem_addr = 32'h200;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      req_cycles += int'(bus_req);
    end
    checks++; if (req_cycles != 4) begin errors++; $display("FAIL to_req_cycles: got %0d want 4", req_cycles); end
    @(negedge clk);
    mem_req = 0;
    #1;
    checks++; if (bus_req !== 1'b0 || fault !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL to_fault: got req=%b fault=%b stall=%b want 0 1 0", bus_req, fault, stall); end
    @(negedge clk);
    #1;
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL to_pulse: got %b want 0", fault); end
    $display("timeout lw addr=200 fault pulse after %0d bus cycles", req_cycles);
  endtask
`endif

  initial begin
    test_reset();
    test_passthrough();
    test_lb();
    test_sh();
    test_sb();
    test_lhu_flush_done();
    test_misaligned();
    test_flush();
`ifdef MEM_LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
